uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Frame sequencer for the UART transmit path. It accepts a parallel byte through a valid/ready handshake and holds one pending byte. It steps the start/data/parity/stop phases on baud ticks and drives the serializer load/shift strobes, the parity bit and the 2-bit output-mux select. The output mux uses the encoding 00 start, 01 serial data, 10 parity, 11 stop/idle.

## Interface
- DATA_WIDTH, 8, data bits per frame (≥2)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- baud_tick  in  1  one-cycle strobe; one bit period per tick
- data_valid  in  1  producer has a byte on p_data
- p_data  in  DATA_WIDTH  byte to send, LSB first
- par_en  in  1  parity bit appended; sampled with p_data
- par_typ  in  1  0 even, 1 odd; sampled with p_data
- data_ready  out  1  block can accept a byte this cycle
- ser_data  out  DATA_WIDTH  latched byte for the serializer
- ser_load  out  1  one-cycle pulse: serializer loads ser_data
- ser_shift  out  1  one-cycle pulse: serializer advances one bit
- parity  out  1  parity bit of the frame in flight
- mux_sel  out  2  output-mux select
- busy  out  1  frame in progress (any state but IDLE)

## Operation
- Accept = data_valid && data_ready at a rising edge. On accept, p_data, par_en and par_typ are captured into a one-entry holding register (hold_vld=1). parity = ^p_data ^ par_typ is computed from the captured byte.
- data_ready = !hold_vld. It is registered. It falls the cycle after accept and rises the cycle after the holding register moves into the active frame.
- States:
  - IDLE (mux 11). If hold_vld=1, go to ALIGN.
  - ALIGN (mux 11). On baud_tick, go to START.
  - START (mux 00). On baud_tick, go to DATA, with cnt=0.
  - DATA (mux 01). On each baud_tick, cnt++. When cnt reaches DATA_WIDTH-1 at a tick, go to PARITY if par_en, else STOP.
  - PARITY (mux 10). On baud_tick, go to STOP.
  - STOP (mux 11). On its final tick, go to START if hold_vld=1, else IDLE.
- Move into the active frame: on entry to START, the holding register is copied to ser_data/parity/active par_en and hold_vld clears. A new byte can therefore be accepted during any later phase of the current frame. This gives back-to-back frames with no idle bit.
- ser_load pulses for exactly the first cycle of START. ser_shift pulses in the cycle after each DATA-state tick except the last one, giving DATA_WIDTH-1 pulses per frame.
- data_valid while data_ready=0: ignored; p_data is not sampled.
- baud_tick in the same cycle as an accept in IDLE: the tick is not consumed. The state enters ALIGN first, so the start bit is always a full tick interval.

## Timing
- All outputs are registered.
- Reset values: state IDLE, mux_sel=11, ser_load=0, ser_shift=0, busy=0, data_ready=1, ser_data=0, parity=0, hold_vld=0, cnt=0.
- Reset asserted mid-frame: all outputs return to their reset values asynchronously. Any held byte is discarded, and the line returns to idle high via mux 11.
- State and mux_sel change in the cycle after the qualifying baud_tick.
- Frame length is 1 + DATA_WIDTH + par_en + stop_bits tick intervals.
- Accept-to-start latency: 1 cycle to ALIGN, then up to one tick interval until START.
- busy rises the cycle after the state leaves IDLE. It falls the cycle the state returns to IDLE.

## Configuration
- UART_TX_CTRL_TWO_STOP_EN defined: STOP lasts two baud_tick intervals, tracked by an internal stop counter. Its final tick is the second one.
- UART_TX_CTRL_TWO_STOP_EN undefined: STOP lasts one interval. No stop counter is built.

## Test plan
- Reset, then 0xA5 with par_en=0 and ticks every 16 clocks: mux sequence 00, 01×8, 11; one ser_load; 7 ser_shift; busy high for 10 intervals; then IDLE.
- 0x07 with par_en=1, par_typ=0: parity=1, mux 10 for one interval before 11. 0x07 with par_typ=1: parity=0.
- 0x3C, then 0xC3 offered during DATA of the first frame: second accept succeeds, data_ready low until the second START, STOP goes straight to START with no idle interval, ser_data=0xC3.
- data_valid held with a third byte while hold_vld=1: not accepted until data_ready returns; every byte is sent exactly once, in order.
- rst_n pulsed low mid-DATA: mux_sel=11, busy=0, data_ready=1 immediately. The next frame starts cleanly from ALIGN.
- Build with UART_TX_CTRL_TWO_STOP_EN and send 0x55 without parity: STOP holds mux 11 for exactly 2 intervals; frame is 11 intervals.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: one-entry byte holding register, start/data/parity/stop
// phase stepping on baud ticks, serializer strobes and output-mux select.
// Optional build macro: UART_TX_CTRL_TWO_STOP_EN (two stop-bit intervals instead of one).
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  data_ready,
  output logic [DATA_WIDTH-1:0] ser_data,
  output logic                  ser_load,
  output logic                  ser_shift,
  output logic                  parity,
  output logic [1:0]            mux_sel,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_DATA   = 2'b01;
  localparam logic [1:0] MUX_PARITY = 2'b10;
  localparam logic [1:0] MUX_IDLE   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  shift_d;
  logic                  take;
  logic                  accept;
  logic                  stop_last;

  logic                  hold_vld_q, hold_vld_d;
  logic [DATA_WIDTH-1:0] hold_data_q;
  logic                  hold_par_en_q;
  logic                  hold_parity_q;
  logic                  act_par_en_q;

`ifdef UART_TX_CTRL_TWO_STOP_EN
  logic                  stop_cnt_q, stop_cnt_d;
`endif

  function automatic logic [1:0] mux_of(input state_t s);
    logic [1:0] m;
    m = MUX_IDLE;
    case (s)
      S_START:  m = MUX_START;
      S_DATA:   m = MUX_DATA;
      S_PARITY: m = MUX_PARITY;
      default:  m = MUX_IDLE;
    endcase
    return m;
  endfunction

  assign accept     = data_valid && data_ready;
  assign hold_vld_d = accept | (hold_vld_q & ~take);

`ifdef UART_TX_CTRL_TWO_STOP_EN
  // Stop counter toggles on each STOP tick and is cleared whenever STOP is left.
  assign stop_cnt_d = (state_q == S_STOP) ? (stop_cnt_q ^ baud_tick) : 1'b0;
  assign stop_last  = stop_cnt_q;
`else
  assign stop_last  = 1'b1;
`endif

  // Next-state logic; 'take' moves the held byte into the active frame on START entry.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = 1'b0;
    take    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hold_vld_q) state_d = S_ALIGN;
      end
      S_ALIGN: begin
        if (baud_tick) begin
          state_d = S_START;
          take    = 1'b1;
        end
      end
      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = act_par_en_q ? S_PARITY : S_STOP;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (baud_tick && stop_last) begin
          if (hold_vld_q) begin
            state_d = S_START;
            take    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and registered control outputs, all derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mux_sel   <= MUX_IDLE;
      busy      <= 1'b0;
      ser_load  <= 1'b0;
      ser_shift <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mux_sel   <= mux_of(state_d);
      busy      <= (state_d != S_IDLE);
      ser_load  <= take;
      ser_shift <= shift_d;
    end
  end

`ifdef UART_TX_CTRL_TWO_STOP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stop_cnt_q <= 1'b0;
    else        stop_cnt_q <= stop_cnt_d;
  end
`endif

  // Holding register and handshake; accept and take can never coincide since
  // accept needs hold_vld=0 and take needs hold_vld=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q    <= 1'b0;
      hold_data_q   <= '0;
      hold_par_en_q <= 1'b0;
      hold_parity_q <= 1'b0;
      data_ready    <= 1'b1;
    end else begin
      hold_vld_q <= hold_vld_d;
      data_ready <= ~hold_vld_d;
      if (accept) begin
        hold_data_q   <= p_data;
        hold_par_en_q <= par_en;
        hold_parity_q <= (^p_data) ^ par_typ;
      end
    end
  end

  // Active-frame copy taken on START entry, so a new byte can be held during this frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_data     <= '0;
      parity       <= 1'b0;
      act_par_en_q <= 1'b0;
    end else if (take) begin
      ser_data     <= hold_data_q;
      parity       <= hold_parity_q;
      act_par_en_q <= hold_par_en_q;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus pushes expected frames, a negedge
// monitor pops them at each ser_load and checks the phase lengths of the frame.
module tb_uart_tx_ctrl;

  localparam int DW = 8;
`ifdef UART_TX_CTRL_TWO_STOP_EN
  localparam int STOP_N = 2;
`else
  localparam int STOP_N = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          baud_tick;
  logic          data_valid;
  logic [DW-1:0] p_data;
  logic          par_en;
  logic          par_typ;
  logic          data_ready;
  logic [DW-1:0] ser_data;
  logic          ser_load;
  logic          ser_shift;
  logic          parity;
  logic [1:0]    mux_sel;
  logic          busy;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_tick  (baud_tick),
    .data_valid (data_valid),
    .p_data     (p_data),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .data_ready (data_ready),
    .ser_data   (ser_data),
    .ser_load   (ser_load),
    .ser_shift  (ser_shift),
    .parity     (parity),
    .mux_sel    (mux_sel),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          par_en;
    logic          parity;
    logic          b2b;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Baud tick: one cycle high every 16 clocks, changed 1 time unit after the edge.
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (15) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  // Monitor: frame opens at ser_load, closes when STOP is left.
  exp_t cur;
  bit   in_frame = 0;
  bit   seen_stop;
  int   t_start, t_data, t_par, t_stop, n_shift;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0;
    end else begin
      if (in_frame && seen_stop && (mux_sel != 2'b11 || !busy)) begin
        check("start_ticks", t_start, 1);
        check("data_ticks", t_data, DW);
        check("parity_ticks", t_par, {31'd0, cur.par_en});
        check("stop_ticks", t_stop, STOP_N);
        check("shift_pulses", n_shift, DW - 1);
        check("back_to_back", {31'd0, (ser_load === 1'b1 && mux_sel === 2'b00)}, {31'd0, cur.b2b});
        in_frame = 0;
      end
      if (ser_load === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_load", 0, 1);
        end else begin
          cur = sb_q.pop_front();
          check("ser_data", ser_data, cur.data);
          check("parity", parity, cur.parity);
          check("ready_at_load", data_ready, 1);
          check("mux_at_load", mux_sel, 2'b00);
          in_frame  = 1;
          seen_stop = 0;
          t_start = 0; t_data = 0; t_par = 0; t_stop = 0; n_shift = 0;
        end
      end
      if (in_frame) begin
        if (mux_sel == 2'b11) seen_stop = 1;
        if (baud_tick) begin
          case (mux_sel)
            2'b00:   t_start++;
            2'b01:   t_data++;
            2'b10:   t_par++;
            default: t_stop++;
          endcase
        end
        if (ser_shift === 1'b1) n_shift++;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt,
                      input logic exp_par, input logic b2b);
    int   budget;
    exp_t e;
    @(posedge clk);
    #1;
    data_valid = 1'b1;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    budget     = 0;
    while (data_ready !== 1'b1 && budget < 2000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 2000) begin
      check("send_timeout", 0, 1);
      data_valid = 1'b0;
    end else begin
      e.data = d; e.par_en = pe; e.parity = exp_par; e.b2b = b2b;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      p_data     = '0;
      check("ready_low_after_accept", data_ready, 0);
    end
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (!(busy === 1'b0 && data_ready === 1'b1 && sb_q.size() == 0 && !in_frame)
           && budget < 4000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 4000) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_mux(input logic [1:0] m);
    int budget = 0;
    while (mux_sel !== m && budget < 2000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 2000) check("mux_wait_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    data_valid = 1'b0;
    p_data     = '0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mux", mux_sel, 2'b11);
    check("rst_busy", busy, 0);
    check("rst_ready", data_ready, 1);
    check("rst_load", ser_load, 0);
    check("rst_shift", ser_shift, 0);
    check("rst_ser_data", ser_data, 0);
    check("rst_parity", parity, 0);
    rst_n = 1'b1;

    // Basic frame without parity.
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Even and odd parity on 0x07 (three ones).
    send(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_idle();
    send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_idle();

    // Back-to-back: second byte held during DATA, third waits for data_ready.
    send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_mux(2'b01);
    send(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle();

    // Reset mid-DATA, then a clean frame through ALIGN.
    send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_mux(2'b01);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_mux", mux_sel, 2'b11);
    check("midrst_busy", busy, 0);
    check("midrst_ready", data_ready, 1);
    check("midrst_ser_data", ser_data, 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h96, 1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("align_busy", busy, 1);
    check("align_mux", mux_sel, 2'b11);
    wait_idle();

    // Stop-length frame without parity.
    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle();

    check("sb_empty", sb_q.size(), 0);
    check("end_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
